// File: rtl/three_pulse_monitor.sv
// Receive-side checker for the three-pulse PWM drive: reconstructs half-cycles
// from the 2-bit drive code and reports period, on-time and pulse count.
module three_pulse_monitor #(
  parameter int unsigned PULSES  = 3,
  parameter int unsigned TIMEOUT = 8000
) (
  input  logic        clk100MHz,
  input  logic        rst_n,
  input  logic [1:0]  pwm_drive,
  input  logic        clr_fault,
  output logic        res_valid,
  output logic        res_polarity,
  output logic [12:0] res_half_period,
  output logic [12:0] res_on_time,
  output logic [2:0]  res_pulses,
  output logic        res_pulse_err,
  output logic        locked,
  output logic        timeout_evt,
  output logic        fault_illegal
);

  localparam logic [12:0] LP_TIMEOUT = 13'(TIMEOUT);
  localparam logic [2:0]  LP_PULSES  = 3'(PULSES);
  localparam logic [12:0] LP_CNT_MAX = '1;
  localparam logic [2:0]  LP_PUL_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_POS, ST_NEG} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_c_prev;
  logic [12:0] r_hp_cnt;
  logic [12:0] r_on_cnt;
  logic [2:0]  r_pulse_cnt;
  logic [12:0] r_idle_cnt;

  logic        w_illegal;
  logic [1:0]  w_c;
  logic [1:0]  w_rise;
  logic [12:0] w_idle_nxt;
  logic        w_start;
  logic        w_boundary;
  logic        w_timeout;
  logic        w_own_level;
  logic        w_own_rise;

  // 11 is cleaned to 00, so both bits can never rise in the same cycle
  assign w_illegal  = (r_sync2 == 2'b11);
  assign w_c        = w_illegal ? 2'b00 : r_sync2;
  assign w_rise     = w_c & ~r_c_prev;
  assign w_idle_nxt = (w_rise != 2'b00) ? '0 :
                      (r_idle_cnt == LP_CNT_MAX) ? r_idle_cnt : r_idle_cnt + 13'd1;

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_c_prev <= '0;
    end else begin
      r_sync1  <= pwm_drive;
      r_sync2  <= r_sync1;
      r_c_prev <= w_c;
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A boundary is checked before the timeout so it wins when both coincide
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_boundary  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise[1]) begin
          w_state_nxt = ST_POS;
          w_start     = 1'b1;
        end else if (w_rise[0]) begin
          w_state_nxt = ST_NEG;
          w_start     = 1'b1;
        end
      end
      ST_POS: begin
        if (w_rise[0]) begin
          w_state_nxt = ST_NEG;
          w_start     = 1'b1;
          w_boundary  = 1'b1;
        end else if (w_idle_nxt >= LP_TIMEOUT) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      ST_NEG: begin
        if (w_rise[1]) begin
          w_state_nxt = ST_POS;
          w_start     = 1'b1;
          w_boundary  = 1'b1;
        end else if (w_idle_nxt >= LP_TIMEOUT) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    locked      = (r_state != ST_IDLE);
    w_own_level = (r_state == ST_POS) ? w_c[1]    : w_c[0];
    w_own_rise  = (r_state == ST_POS) ? w_rise[1] : w_rise[0];
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_hp_cnt    <= '0;
      r_on_cnt    <= '0;
      r_pulse_cnt <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_idle_cnt <= w_idle_nxt;
      if (w_start) begin
        r_hp_cnt    <= '0;
        r_on_cnt    <= 13'd1;
        r_pulse_cnt <= 3'd1;
      end else begin
        if (r_hp_cnt != LP_CNT_MAX)
          r_hp_cnt <= r_hp_cnt + 13'd1;
        if (w_own_level && (r_on_cnt != LP_CNT_MAX))
          r_on_cnt <= r_on_cnt + 13'd1;
        if (w_own_rise && (r_pulse_cnt != LP_PUL_MAX))
          r_pulse_cnt <= r_pulse_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      res_valid       <= 1'b0;
      res_polarity    <= 1'b0;
      res_half_period <= '0;
      res_on_time     <= '0;
      res_pulses      <= '0;
      res_pulse_err   <= 1'b0;
      timeout_evt     <= 1'b0;
      fault_illegal   <= 1'b0;
    end else begin
      res_valid   <= w_boundary;
      timeout_evt <= w_timeout;
      if (w_boundary) begin
        res_polarity    <= (r_state == ST_POS);
        res_half_period <= (r_hp_cnt == LP_CNT_MAX) ? r_hp_cnt : r_hp_cnt + 13'd1;
        res_on_time     <= r_on_cnt;
        res_pulses      <= r_pulse_cnt;
        res_pulse_err   <= (r_pulse_cnt != LP_PULSES);
      end
      if (w_illegal)      fault_illegal <= 1'b1;
      else if (clr_fault) fault_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_three_pulse_monitor.sv
// Directed bench for three_pulse_monitor: each task drives one scenario and
// checks results captured by a res_valid monitor against hand-computed values.
module tb_three_pulse_monitor;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pwm_drive;
  logic        clr_fault;
  logic        res_valid;
  logic        res_polarity;
  logic [12:0] res_half_period;
  logic [12:0] res_on_time;
  logic [2:0]  res_pulses;
  logic        res_pulse_err;
  logic        locked;
  logic        timeout_evt;
  logic        fault_illegal;

  typedef struct packed {
    logic        pol;
    logic [12:0] hp;
    logic [12:0] on;
    logic [2:0]  pul;
    logic        err;
  } res_t;

  res_t q[$];
  int   n_tmo;
  int   n_checks;
  int   n_errors;

  three_pulse_monitor #(.PULSES(3), .TIMEOUT(8000)) dut (
    .clk100MHz      (clk),
    .rst_n          (rst_n),
    .pwm_drive      (pwm_drive),
    .clr_fault      (clr_fault),
    .res_valid      (res_valid),
    .res_polarity   (res_polarity),
    .res_half_period(res_half_period),
    .res_on_time    (res_on_time),
    .res_pulses     (res_pulses),
    .res_pulse_err  (res_pulse_err),
    .locked         (locked),
    .timeout_evt    (timeout_evt),
    .fault_illegal  (fault_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (res_valid)
      q.push_back({res_polarity, res_half_period, res_on_time, res_pulses, res_pulse_err});
    if (timeout_evt) n_tmo++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [1:0] code, input int n);
    pwm_drive = code;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    pwm_drive = 2'b00;
    clr_fault = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    q.delete();
    n_tmo = 0;
  endtask

  // Compares captured result idx with the expected tuple
  task automatic cmp_res(input string name, input int idx, input res_t exp);
    res_t got;
    got = (idx < q.size()) ? q[idx] : '0;
    n_checks++;
    if (idx >= q.size() || got !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got pol=%0d hp=%0d on=%0d pul=%0d err=%0d (n=%0d) expected pol=%0d hp=%0d on=%0d pul=%0d err=%0d",
               name, idx, got.pol, got.hp, got.on, got.pul, got.err, q.size(),
               exp.pol, exp.hp, exp.on, exp.pul, exp.err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({res_valid, res_polarity, res_half_period, res_on_time, res_pulses, res_pulse_err,
         locked, timeout_evt, fault_illegal} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got hp=%0d on=%0d pul=%0d locked=%0d fault=%0d expected all 0",
               res_half_period, res_on_time, res_pulses, locked, fault_illegal);
    end
  endtask

  task automatic half(input logic [1:0] code, input int np, input int width,
                      input int spacing, input int total);
    for (int i = 0; i < np; i++) begin
      hold(code, width);
      hold(2'b00, spacing - width);
    end
    hold(2'b00, total - np * spacing);
  endtask

  task automatic test_nominal();
    res_t exp;
    do_reset();
    half(2'b10, 3, 300, 800, 2500);
    half(2'b01, 3, 300, 800, 2500);
    half(2'b10, 3, 300, 800, 2500);
    half(2'b01, 3, 300, 800, 2500);
    hold(2'b10, 1);
    hold(2'b00, 5);
    n_checks++;
    if (q.size() != 4) begin
      n_errors++;
      $display("FAIL nominal_count: got %0d results expected 4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      exp.pol = (i % 2 == 0); exp.hp = 13'd2500; exp.on = 13'd900;
      exp.pul = 3'd3; exp.err = 1'b0;
      cmp_res("nominal", i, exp);
    end
  endtask

  task automatic test_startup_timeout();
    res_t exp;
    do_reset();
    hold(2'b00, 3);
    pwm_drive = 2'b01;
    tick();
    tick();
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL startup_locked_early: got %0d expected 0", locked);
    end
    tick();
    n_checks++;
    if (locked !== 1'b1 || q.size() != 0) begin
      n_errors++;
      $display("FAIL startup_locked: got locked=%0d results=%0d expected locked=1 results=0",
               locked, q.size());
    end
    hold(2'b01, 297);
    hold(2'b00, 2200);
    // last rising edge: the 10 that closes the startup half-cycle
    hold(2'b10, 1);
    hold(2'b00, 8001);
    exp.pol = 1'b0; exp.hp = 13'd2500; exp.on = 13'd300; exp.pul = 3'd1; exp.err = 1'b1;
    cmp_res("startup", 0, exp);
    n_checks++;
    if (timeout_evt !== 1'b0 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_early: got evt=%0d locked=%0d expected evt=0 locked=1",
               timeout_evt, locked);
    end
    tick();
    n_checks++;
    if (timeout_evt !== 1'b1 || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_evt: got evt=%0d locked=%0d expected evt=1 locked=0",
               timeout_evt, locked);
    end
    tick();
    n_checks++;
    if (timeout_evt !== 1'b0 || n_tmo != 1) begin
      n_errors++;
      $display("FAIL timeout_strobe: got evt=%0d count=%0d expected evt=0 count=1",
               timeout_evt, n_tmo);
    end
    hold(2'b10, 3);
    n_checks++;
    if (locked !== 1'b1 || q.size() != 1) begin
      n_errors++;
      $display("FAIL timeout_reenter: got locked=%0d results=%0d expected locked=1 results=1",
               locked, q.size());
    end
  endtask

  task automatic test_illegal();
    res_t exp;
    do_reset();
    hold(2'b10, 300);
    hold(2'b00, 100);
    pwm_drive = 2'b11;
    tick();
    pwm_drive = 2'b00;
    tick();
    n_checks++;
    if (fault_illegal !== 1'b0) begin
      n_errors++;
      $display("FAIL illegal_early: got %0d expected 0", fault_illegal);
    end
    tick();
    n_checks++;
    if (fault_illegal !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_set: got %0d expected 1", fault_illegal);
    end
    hold(2'b00, 397);
    half(2'b10, 2, 300, 800, 1700);
    hold(2'b01, 1);
    hold(2'b00, 4);
    n_checks++;
    if (q.size() != 1 || fault_illegal !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_hold: got results=%0d fault=%0d expected results=1 fault=1",
               q.size(), fault_illegal);
    end
    exp.pol = 1'b1; exp.hp = 13'd2500; exp.on = 13'd900; exp.pul = 3'd3; exp.err = 1'b0;
    cmp_res("illegal", 0, exp);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    n_checks++;
    if (fault_illegal !== 1'b0) begin
      n_errors++;
      $display("FAIL illegal_clear: got %0d expected 0", fault_illegal);
    end
    pwm_drive = 2'b11;
    tick();
    pwm_drive = 2'b00;
    tick();
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    n_checks++;
    if (fault_illegal !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_set_wins: got %0d expected 1", fault_illegal);
    end
  endtask

  task automatic test_pulse_err_saturation();
    res_t exp;
    do_reset();
    half(2'b10, 2, 100, 200, 1000);
    hold(2'b01, 1);
    hold(2'b00, 4);
    exp.pol = 1'b1; exp.hp = 13'd1000; exp.on = 13'd200; exp.pul = 3'd2; exp.err = 1'b1;
    cmp_res("pulse_err", 0, exp);
    do_reset();
    half(2'b10, 9, 1, 1000, 9000);
    hold(2'b01, 1);
    hold(2'b00, 4);
    exp.pol = 1'b1; exp.hp = 13'd8191; exp.on = 13'd9; exp.pul = 3'd7; exp.err = 1'b1;
    cmp_res("saturation", 0, exp);
  endtask

  task automatic test_back_to_back();
    res_t exp;
    do_reset();
    hold(2'b10, 1); hold(2'b00, 1);
    hold(2'b01, 1); hold(2'b00, 1);
    hold(2'b10, 1); hold(2'b00, 1);
    hold(2'b01, 1); hold(2'b00, 5);
    n_checks++;
    if (q.size() != 3) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d results expected 3", q.size());
    end
    for (int i = 0; i < 3; i++) begin
      exp.pol = (i % 2 == 0); exp.hp = 13'd2; exp.on = 13'd1; exp.pul = 3'd1; exp.err = 1'b1;
      cmp_res("b2b", i, exp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold(2'b11, 1);
    hold(2'b10, 300);
    hold(2'b00, 700);
    hold(2'b01, 300);
    hold(2'b00, 700);
    hold(2'b10, 300);
    hold(2'b00, 100);
    n_checks++;
    if (locked !== 1'b1 || q.size() != 2 || fault_illegal !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_pre: got locked=%0d results=%0d fault=%0d expected 1 2 1",
               locked, q.size(), fault_illegal);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({res_valid, res_polarity, res_half_period, res_on_time, res_pulses, res_pulse_err,
         locked, timeout_evt, fault_illegal} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: got hp=%0d on=%0d pul=%0d locked=%0d fault=%0d expected all 0",
               res_half_period, res_on_time, res_pulses, locked, fault_illegal);
    end
    tick();
    rst_n = 1'b1;
    q.delete();
    hold(2'b00, 5);
    hold(2'b01, 300);
    hold(2'b00, 10);
    n_checks++;
    if (q.size() != 0 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_after: got results=%0d locked=%0d expected results=0 locked=1",
               q.size(), locked);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    n_tmo     = 0;
    rst_n     = 1'b0;
    pwm_drive = 2'b00;
    clr_fault = 1'b0;
    test_reset();
    test_nominal();
    test_startup_timeout();
    test_illegal();
    test_pulse_err_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
